// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle integer execute unit with a valid/ready handshake.
// Single-cycle ops finish in one cycle. MUL is a 32-step shift-add, and shifts move one bit per cycle.
// Optional build macro ALU_FAST_SHIFT_EN replaces the iterative shift path with a
// one-cycle barrel shifter. The results are identical in both builds.
module alu_exec_unit #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [3:0]      alu_op_i,
    input  logic            flag_i,
    input  logic            eq_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            taken_o
);

    localparam int CNT_W = SHAMT_W + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

    state_t            state_q, state_d;
    logic              eq_q, eq_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              taken_q, taken_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   mul_acc;
    logic              is_mul;
`ifndef ALU_FAST_SHIFT_EN
    logic              left_q, left_d;
    logic              arith_q, arith_d;
    logic              is_shift;
    logic [XLEN-1:0]   shift_step;
`endif

    function automatic logic branch_taken(input logic eq, input logic [XLEN-1:0] r);
        return eq ? (r == '0) : (r != '0);
    endfunction

    assign shamt  = src2_i[SHAMT_W-1:0];
    assign is_mul = (alu_op_i == 4'b1000);
    assign mul_acc = acc_q + (opb_q[0] ? opa_q : '0);
`ifndef ALU_FAST_SHIFT_EN
    assign is_shift   = !alu_op_i[3] && (alu_op_i[1:0] == 2'b01);
    assign shift_step = left_q  ? {opa_q[XLEN-2:0], 1'b0} :
                        arith_q ? {opa_q[XLEN-1], opa_q[XLEN-1:1]} :
                                  {1'b0, opa_q[XLEN-1:1]};
`endif

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign result_o    = result_q;
    assign taken_o     = taken_q;

    // Single-cycle result straight from the request inputs (shifts only when shamt is 0, or in the fast build).
    always_comb begin
        alu_res = '0;
        if (!alu_op_i[3]) begin
            case (alu_op_i[2:0])
                3'b000: alu_res = flag_i ? (src1_i - src2_i) : (src1_i + src2_i);
`ifdef ALU_FAST_SHIFT_EN
                3'b001: alu_res = src1_i << shamt;
                3'b101: begin
                    if (flag_i)
                        alu_res = $signed(src1_i) >>> shamt;
                    else
                        alu_res = src1_i >> shamt;
                end
`else
                3'b001: alu_res = src1_i;
                3'b101: alu_res = src1_i;
`endif
                3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
                3'b011: alu_res = {{(XLEN-1){1'b0}}, (src1_i < src2_i)};
                3'b100: alu_res = src1_i ^ src2_i;
                3'b110: alu_res = src1_i | src2_i;
                default: alu_res = src1_i & src2_i;
            endcase
        end
    end

    // Next-state and datapath update for the IDLE/SHIFT/MUL/DONE controller.
    always_comb begin
        state_d  = state_q;
        eq_d     = eq_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        taken_d  = taken_q;
        cnt_d    = cnt_q;
`ifndef ALU_FAST_SHIFT_EN
        left_d   = left_q;
        arith_d  = arith_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    eq_d  = eq_i;
                    opa_d = src1_i;
                    opb_d = src2_i;
                    acc_d = '0;
`ifndef ALU_FAST_SHIFT_EN
                    left_d  = (alu_op_i[2:0] == 3'b001);
                    arith_d = flag_i;
`endif
                    if (is_mul) begin
                        cnt_d   = CNT_W'(XLEN);
                        state_d = MUL;
                    end
`ifndef ALU_FAST_SHIFT_EN
                    else if (is_shift && (shamt != '0)) begin
                        cnt_d   = {1'b0, shamt};
                        state_d = SHIFT;
                    end
`endif
                    else begin
                        result_d = alu_res;
                        taken_d  = branch_taken(eq_i, alu_res);
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
`ifndef ALU_FAST_SHIFT_EN
                opa_d = shift_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = shift_step;
                    taken_d  = branch_taken(eq_q, shift_step);
                    state_d  = DONE;
                end
`else
                state_d = IDLE;
`endif
            end
            MUL: begin
                acc_d = mul_acc;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = mul_acc;
                    taken_d  = branch_taken(eq_q, mul_acc);
                    state_d  = DONE;
                end
            end
            default: begin
                if (out_ready_i)
                    state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            eq_q     <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            taken_q  <= 1'b0;
            cnt_q    <= '0;
`ifndef ALU_FAST_SHIFT_EN
            left_q   <= 1'b0;
            arith_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            eq_q     <= eq_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            taken_q  <= taken_d;
            cnt_q    <= cnt_d;
`ifndef ALU_FAST_SHIFT_EN
            left_q   <= left_d;
            arith_q  <= arith_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed literal cases plus randomized ops,
// compared every cycle against a behavioural model of results, latency and handshake.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic        flag;
    logic        eq;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        taken;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    // Model state: request outstanding, edges left before the result shows, expected outputs.
    bit          m_busy = 0;
    int          m_rem  = 0;
    logic [31:0] m_res  = '0;
    logic        m_taken = 1'b0;

`ifdef ALU_FAST_SHIFT_EN
    localparam int SRA4_LAT = 1;
    localparam int SLL1_LAT = 1;
`else
    localparam int SRA4_LAT = 5;
    localparam int SLL1_LAT = 2;
`endif

    alu_exec_unit dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .alu_op_i    (alu_op),
        .flag_i      (flag),
        .eq_i        (eq),
        .src1_i      (src1),
        .src2_i      (src2),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .taken_o     (taken)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic f,
                                               input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [63:0] prod;
        sh = b % 32;
        case (op)
            4'd0: return f ? a - b : a + b;
            4'd1: return a << sh;
            4'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3: return (a < b) ? 32'd1 : 32'd0;
            4'd4: return a ^ b;
            4'd5: begin
                if (f) return $signed(a) >>> sh;
                return a >> sh;
            end
            4'd6: return a | b;
            4'd7: return a & b;
            4'd8: begin
                prod = {32'd0, a} * {32'd0, b};
                return prod[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'd8) return 33;
`ifndef ALU_FAST_SHIFT_EN
        if (op == 4'd1 || op == 4'd5) return (b % 32 == 0) ? 1 : int'(b % 32) + 1;
`endif
        return 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks acceptance and countdown to the result from its own view of readiness.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0;
            m_rem  = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy  = 1;
                m_rem   = ref_latency(alu_op, src2) - 1;
                m_res   = ref_result(alu_op, flag, src1, src2);
                m_taken = eq ? (m_res == 0) : (m_res != 0);
            end
        end else if (m_rem > 0) begin
            m_rem--;
        end else if (out_ready) begin
            m_busy = 0;
        end
    end

    // Per-cycle comparison of handshake and result against the model.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, (m_busy && m_rem == 0)});
            if (m_busy && m_rem == 0) begin
                checkOutput("result", result, m_res);
                checkOutput("taken", {31'd0, taken}, {31'd0, m_taken});
            end
        end
    end

    // Issue one op at a negedge, scramble inputs while busy, wait for the result, stall, then consume it.
    task automatic applyStimulus(input string name, input logic [3:0] op, input logic f,
                                 input logic e, input logic [31:0] a, input logic [31:0] b,
                                 input int stall, input bit directed, input logic [31:0] lit_res,
                                 input logic lit_taken, input int lit_lat);
        int lat;
        bit seen;
        alu_op   = op;
        flag     = f;
        eq       = e;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        lat  = 0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
            if (out_valid) begin
                seen = 1;
                break;
            end
            in_valid  = 1'($urandom_range(0, 1));
            alu_op    = 4'($urandom_range(0, 15));
            src1      = $urandom;
            src2      = $urandom;
            out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        if (!seen) begin
            checkOutput({name, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'(ref_latency(op, b)));
        if (directed) begin
            checkOutput({name, "_lit_latency"}, 32'(lat), 32'(lit_lat));
            checkOutput({name, "_lit_result"}, result, lit_res);
            checkOutput({name, "_lit_taken"}, {31'd0, taken}, {31'd0, lit_taken});
        end
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) @(negedge clk);
        if (directed && stall > 0) begin
            checkOutput({name, "_stall_result"}, result, lit_res);
            checkOutput({name, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int seen_valid;
        logic [3:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = 4'd0;
        flag      = 1'b0;
        eq        = 1'b0;
        src1      = '0;
        src2      = '0;

        // Reset held for three edges.
        @(posedge clk);
        started = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_taken", {31'd0, taken}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Subtract and branch-equal senses.
        applyStimulus("sub_5_7", 4'd0, 1'b1, 1'b1, 32'd5, 32'd7, 0, 1, 32'hFFFF_FFFE, 1'b0, 1);
        applyStimulus("beq_7_7", 4'd0, 1'b1, 1'b1, 32'd7, 32'd7, 0, 1, 32'd0, 1'b1, 1);
        applyStimulus("bne_7_7", 4'd0, 1'b1, 1'b0, 32'd7, 32'd7, 0, 1, 32'd0, 1'b0, 1);

        // Shifts: arithmetic right, zero amount, masked amount, masked left shift.
        applyStimulus("sra_4", 4'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 0, 1, 32'hF800_0000, 1'b1, SRA4_LAT);
        applyStimulus("sra_0", 4'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd0, 0, 1, 32'h8000_0000, 1'b1, 1);
        applyStimulus("sra_36", 4'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd36, 0, 1, 32'hF800_0000, 1'b1, SRA4_LAT);
        applyStimulus("sll_33", 4'd1, 1'b0, 1'b0, 32'h4000_0001, 32'd33, 0, 1, 32'h8000_0002, 1'b1, SLL1_LAT);

        // Signed and unsigned compares used as branches.
        applyStimulus("blt", 4'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1, 32'd1, 1'b1, 1);
        applyStimulus("bltu", 4'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1, 32'd0, 1'b0, 1);
        applyStimulus("bgeu", 4'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 0, 1, 32'd0, 1'b1, 1);

        // Multiply, reserved opcode, and a ten-cycle output stall.
        applyStimulus("mul", 4'd8, 1'b0, 1'b0, 32'h0001_0003, 32'h0002_0005, 0, 1, 32'h000B_000F, 1'b1, 33);
        applyStimulus("op_1001", 4'd9, 1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1, 32'd0, 1'b1, 1);
        applyStimulus("stall_sub", 4'd0, 1'b1, 1'b0, 32'd100, 32'd1, 10, 1, 32'd99, 1'b1, 1);

        // Reset in the tenth MUL cycle aborts it.
        alu_op   = 4'd8;
        flag     = 1'b0;
        eq       = 1'b0;
        src1     = 32'd3;
        src2     = 32'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("abort_result", result, 32'd0);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        checkOutput("abort_no_result", 32'(seen_valid), 32'd0);

        // Randomized ops, biased toward equal operands and interesting shift amounts.
        for (int n = 0; n < 60; n++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
            if ($urandom_range(0, 1) == 1) r_b = r_b & 32'h0000_003F;
            applyStimulus("rand", r_op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          r_a, r_b, int'($urandom_range(0, 3)), 0, 32'd0, 1'b0, 0);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
